jtcontra_colmix_mc: RTL and testbench
=====================================

// Module: jtcontra_colmix_mc
// PURPOSE
//  Multi-layer colour mixer with CPU-writable palette RAM; parametrised successor of the single-layer colmix.
//  Takes LAYERS pixel streams from jtcontra_gfx instances and resolves transparency and priority.
//  Looks up a 15-bit xBGR palette and outputs RGB555 with blanking delayed to match the pipeline.
//  Sits between the gfx engines and the video output of every multi-chip Konami core.
// PARAMETERS
//  LAYERS    2   number of pixel input layers (>=2)
//  PXLW      7   bits per layer pixel: [3:0] colour (0 = transparent), [PXLW-1:4] palette bank
//  AW        9   palette byte-address width; 2^(AW-1) 16-bit entries; AW-1 >= PXLW+$clog2(LAYERS)
// PORTS
//  clk        in   1             system clock (48 MHz)
//  rstn       in   1             synchronous reset, active low
//  pxl_cen    in   1             pixel clock enable (one clk wide)
//  cpu_cen    in   1             CPU clock enable; gates palette writes
//  LHBL       in   1             horizontal blank, active low
//  LVBL       in   1             vertical blank, active low
//  pal_cs     in   1             CPU palette chip select
//  cpu_rnw    in   1             1 = read, 0 = write
//  cpu_addr   in   AW            CPU byte address into palette
//  cpu_dout   in   8             CPU write data
//  pal_dout   out  8             CPU read data
//  pxl_in     in   LAYERS*PXLW   layer pixels, layer k at [k*PXLW +: PXLW]
//  layer_en   in   LAYERS        per-layer enable (debug/gfx_en); 0 forces layer transparent
//  prio       in   $clog2(LAYERS) index of top layer; rest follow in ascending index order, wrapping
//  LHBL_dly   out  1             LHBL delayed to match colour outputs
//  LVBL_dly   out  1             LVBL delayed to match colour outputs
//  red/green/blue out 5 each     RGB555 output
// BEHAVIOUR
//  Reset (rstn low at clk edge): red/green/blue=0, LHBL_dly=LVBL_dly=0, pal_dout=0, pipeline regs cleared.
//   Palette RAM contents are NOT cleared. Reset mid-line: outputs zero from next edge; recover after 2 pxl_cen.
//  Palette word n = bytes 2n (low) / 2n+1 (high); low = {G[2:0],R[4:0]}, high = {x,B[4:0],G[4:3]}.
//  CPU write: pal_cs & ~cpu_rnw & cpu_cen at edge -> byte written that edge; one byte per cpu_cen strobe.
//  CPU read: pal_dout = byte at cpu_addr registered every clk (1 clk latency), regardless of cpu_cen.
//  Pixel pipeline, advancing only on pxl_cen:
//   S0: layer k opaque iff layer_en[k] & pxl_in[k][3:0]!=0. Scan order prio, prio+1, ... mod LAYERS;
//       first opaque layer wins. None opaque -> lowest-priority layer (prio-1 mod LAYERS) with its raw pixel
//       (backdrop colour 0 of its bank). Palette index = {winner_id, winner_pxl}, zero-extended to AW-1.
//       Register index + LHBL/LVBL.
//   S1: palette video port read (sync RAM, data ready next clk, captured on next pxl_cen).
//   S2: unpack to RGB; if delayed LHBL & LVBL both high drive colour, else drive 0. Register outputs.
//  Latency: pxl_in sampled on pxl_cen N -> RGB valid after pxl_cen N+2; LHBL_dly/LVBL_dly same 2-pxl delay.
//  pxl_cen low: all pipeline regs hold; outputs stable.
//  Same-word CPU write and video read in one clk: video gets old data (read-before-write); no stall.
//  prio/layer_en sampled in S0 only; a change mid-line affects pixels from next pxl_cen, no glitch.
//  Address arithmetic unsigned; index bits above AW-1 (when configured wider) are dropped, never wrap into CPU side.
// TESTING
//  1 Reset: hold rstn=0 4 clk with LHBL=LVBL=1 -> RGB=0, LHBL_dly=LVBL_dly=0; after release, palette bytes unchanged.
//  2 CPU write 0x1F@0x002, 0x7C@0x003, cpu_cen pulses -> readback 0x1F/0x7C after 1 clk; entry1 = R=31,G=0,B=31.
//  3 Priority: LAYERS=2, prio=0, layer0=0x01, layer1=0x12 -> entry {0,0x01}; prio=1 -> entry {1,0x12}; 2-pxl latency.
//  4 Transparency: layer0=0x10, layer1=0x25, prio=0 -> layer1 wins; both colour 0 (0x30,0x40), prio=0 -> backdrop {1,0x40}.
//  5 Blanking: LHBL low for 1 pxl with opaque pixel -> RGB=0 and LHBL_dly low exactly 2 pxl_cen later, 1 pxl wide.
//  6 Collision: CPU writes entry 5 on same clk video reads entry 5 -> old colour out, new colour on next pixel using it.

Source files
------------

// File: rtl/jtcontra_colmix_mc_if.sv
// CPU-side palette bus for the multi-layer colour mixer.
// The CPU (master) drives address/data/strobes; the mixer (slave) returns read data.
interface jtcontra_colmix_mc_if #(
  parameter int AW = 9
);
  logic          cpu_cen;
  logic          pal_cs;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic [7:0]    pal_dout;

  modport master (
    output cpu_cen, pal_cs, cpu_rnw, cpu_addr, cpu_dout,
    input  pal_dout
  );

  modport slave (
    input  cpu_cen, pal_cs, cpu_rnw, cpu_addr, cpu_dout,
    output pal_dout
  );
endinterface

// File: rtl/jtcontra_colmix_mc.sv
// Multi-layer colour mixer: priority/transparency resolve, CPU-writable xBGR palette,
// RGB555 output. Three pxl_cen stages: layer select, palette read, blank-gated output.
module jtcontra_colmix_mc #(
  parameter int LAYERS = 2,
  parameter int PXLW   = 7,
  parameter int AW     = 9,
  localparam int PW    = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     pxl_cen,
  input  logic                     LHBL,
  input  logic                     LVBL,
  jtcontra_colmix_mc_if.slave      cpu,
  input  logic [LAYERS*PXLW-1:0]   pxl_in,
  input  logic [LAYERS-1:0]        layer_en,
  input  logic [PW-1:0]            prio,
  output logic                     LHBL_dly,
  output logic                     LVBL_dly,
  output logic [4:0]               red,
  output logic [4:0]               green,
  output logic [4:0]               blue
);
  localparam int IW    = AW - 1;
  localparam int IDW   = PW + PXLW;
  localparam int DEPTH = 1 << IW;

  // Each palette word is split into its two CPU-visible bytes
  logic [7:0] lo_mem [DEPTH];
  logic [7:0] hi_mem [DEPTH];

  logic             pal_we;
  logic             found;
  logic             take;
  int               scan_k;
  int               win_id;
  logic [PXLW-1:0]  scan_pxl;
  logic [PXLW-1:0]  win_pxl;
  logic [IDW+IW-1:0] idx_full;
  logic [IW-1:0]    sel_idx;

  logic [IW-1:0] idx_d, idx_q;
  logic [1:0]    bl0_d, bl0_q;
  logic [1:0]    bl1_d, bl1_q;
  logic [1:0]    dly_d, dly_q;
  logic [14:0]   vid_d, vid_q;
  logic [14:0]   rgb_d, rgb_q;
  logic [7:0]    pal_dout_d, pal_dout_q;

  assign pal_we = cpu.pal_cs & ~cpu.cpu_rnw & cpu.cpu_cen;

  // Priority scan: first opaque layer from prio upward wins; else backdrop of prio-1
  always_comb begin
    found    = 1'b0;
    take     = 1'b0;
    scan_k   = 0;
    scan_pxl = '0;
    win_id   = (int'(prio) == 0) ? LAYERS - 1 : int'(prio) - 1;
    for (int i = 0; i < LAYERS; i++) begin
      scan_k   = (int'(prio) + i >= LAYERS) ? int'(prio) + i - LAYERS : int'(prio) + i;
      scan_pxl = PXLW'(pxl_in >> (scan_k * PXLW));
      take     = !found && 1'(layer_en >> scan_k) && (scan_pxl[3:0] != 4'd0);
      win_id   = take ? scan_k : win_id;
      found    = found | take;
    end
    win_pxl            = PXLW'(pxl_in >> (win_id * PXLW));
    idx_full           = '0;
    idx_full[IDW-1:0]  = {PW'(win_id), win_pxl};
    sel_idx            = idx_full[IW-1:0];
  end

  // Pipeline next-state: every stage holds unless pxl_cen advances it
  always_comb begin
    idx_d = idx_q;
    bl0_d = bl0_q;
    vid_d = vid_q;
    bl1_d = bl1_q;
    rgb_d = rgb_q;
    dly_d = dly_q;
    if (pxl_cen) begin
      idx_d = sel_idx;
      bl0_d = {LHBL, LVBL};
      vid_d = {hi_mem[idx_q][6:0], lo_mem[idx_q]};
      bl1_d = bl0_q;
      rgb_d = (bl1_q == 2'b11) ? vid_q : 15'd0;
      dly_d = bl1_q;
    end else begin
      idx_d = idx_q;
    end
    pal_dout_d = cpu.cpu_addr[0] ? hi_mem[cpu.cpu_addr[AW-1:1]] : lo_mem[cpu.cpu_addr[AW-1:1]];
  end

  // Pipeline and CPU read-data registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_q      <= '0;
      bl0_q      <= 2'b00;
      vid_q      <= 15'd0;
      bl1_q      <= 2'b00;
      rgb_q      <= 15'd0;
      dly_q      <= 2'b00;
      pal_dout_q <= 8'd0;
    end else begin
      idx_q      <= idx_d;
      bl0_q      <= bl0_d;
      vid_q      <= vid_d;
      bl1_q      <= bl1_d;
      rgb_q      <= rgb_d;
      dly_q      <= dly_d;
      pal_dout_q <= pal_dout_d;
    end
  end

  // Palette byte writes; contents survive reset and video reads see pre-write data
  always_ff @(posedge clk) begin
    if (pal_we) begin
      if (cpu.cpu_addr[0]) begin
        hi_mem[cpu.cpu_addr[AW-1:1]] <= cpu.cpu_dout;
      end else begin
        lo_mem[cpu.cpu_addr[AW-1:1]] <= cpu.cpu_dout;
      end
    end
  end

  assign cpu.pal_dout = pal_dout_q;
  assign red          = rgb_q[4:0];
  assign green        = rgb_q[9:5];
  assign blue         = rgb_q[14:10];
  assign LHBL_dly     = dly_q[1];
  assign LVBL_dly     = dly_q[0];
endmodule

// File: tb/tb_jtcontra_colmix_mc.sv
// Randomised self-checking bench for jtcontra_colmix_mc against a palette/priority reference model.
module tb_jtcontra_colmix_mc;
  localparam int L    = 2;
  localparam int PXLW = 7;
  localparam int AW   = 9;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             pxl_cen = 1'b0;
  logic             LHBL = 1'b1;
  logic             LVBL = 1'b1;
  logic [L*PXLW-1:0] pxl_in = '0;
  logic [L-1:0]     layer_en = '1;
  logic [0:0]       prio = '0;
  logic             LHBL_dly, LVBL_dly;
  logic [4:0]       red, green, blue;

  jtcontra_colmix_mc_if #(.AW(AW)) cpu_bus ();

  jtcontra_colmix_mc #(.LAYERS(L), .PXLW(PXLW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .cpu(cpu_bus), .pxl_in(pxl_in), .layer_en(layer_en), .prio(prio),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pal_m [512];
  int hidx [1024];
  int hh [1024];
  int hv [1024];
  int hcol [1024];
  int n_pix = 0;
  int exp_rgb = 0, exp_h = 0, exp_v = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RGB packed as {R,G,B}, 5 bits each, decoded from the two palette bytes
  function automatic int colour(input int idx);
    int lo, hi, r, g, b;
    lo = pal_m[2*idx];
    hi = pal_m[2*idx+1];
    r  = lo & 31;
    g  = (lo >> 5) | ((hi & 3) << 3);
    b  = (hi >> 2) & 31;
    return (r << 10) | (g << 5) | b;
  endfunction

  function automatic int ref_idx(input int pix, input int en, input int pr);
    int ly, p;
    for (int r = 0; r < L; r++) begin
      ly = (pr + r) % L;
      p  = (pix >> (ly * PXLW)) & 127;
      if (((en >> ly) & 1) == 1 && (p & 15) != 0) return ly * 128 + p;
    end
    ly = (pr + L - 1) % L;
    return ly * 128 + ((pix >> (ly * PXLW)) & 127);
  endfunction

  task automatic check_out(input string tag);
    check_val({tag, "_rgb"}, {17'd0, red, green, blue}, exp_rgb);
    check_val({tag, "_hdly"}, {31'd0, LHBL_dly}, exp_h);
    check_val({tag, "_vdly"}, {31'd0, LVBL_dly}, exp_v);
  endtask

  // One pixel: inputs presented with a one-clk pxl_cen, optional same-clk CPU write
  task automatic pstep(input int pix, input int en, input int pr, input int h, input int v,
                       input int wa, input int wd);
    pxl_in   = 14'(pix);
    layer_en = 2'(en);
    prio     = 1'(pr);
    LHBL     = 1'(h);
    LVBL     = 1'(v);
    pxl_cen  = 1'b1;
    if (wa >= 0) begin
      cpu_bus.pal_cs   = 1'b1;
      cpu_bus.cpu_rnw  = 1'b0;
      cpu_bus.cpu_cen  = 1'b1;
      cpu_bus.cpu_addr = 9'(wa);
      cpu_bus.cpu_dout = 8'(wd);
    end
    if (n_pix >= 1) hcol[n_pix-1] = colour(hidx[n_pix-1]);
    hidx[n_pix] = ref_idx(pix, en, pr);
    hh[n_pix]   = h;
    hv[n_pix]   = v;
    if (wa >= 0) pal_m[wa] = wd;
    @(posedge clk); #1;
    pxl_cen         = 1'b0;
    cpu_bus.pal_cs  = 1'b0;
    cpu_bus.cpu_rnw = 1'b1;
    cpu_bus.cpu_cen = 1'b0;
    if (n_pix >= 2) begin
      exp_h   = hh[n_pix-2];
      exp_v   = hv[n_pix-2];
      exp_rgb = (exp_h == 1 && exp_v == 1) ? hcol[n_pix-2] : 0;
    end else begin
      exp_h = 0; exp_v = 0; exp_rgb = 0;
    end
    check_out("pix");
    n_pix++;
  endtask

  task automatic cpu_write(input int a, input int d, input int cen);
    cpu_bus.pal_cs   = 1'b1;
    cpu_bus.cpu_rnw  = 1'b0;
    cpu_bus.cpu_cen  = 1'(cen);
    cpu_bus.cpu_addr = 9'(a);
    cpu_bus.cpu_dout = 8'(d);
    @(posedge clk); #1;
    cpu_bus.pal_cs  = 1'b0;
    cpu_bus.cpu_rnw = 1'b1;
    cpu_bus.cpu_cen = 1'b0;
    if (cen != 0) pal_m[a] = d;
  endtask

  task automatic cpu_read(input int a);
    cpu_bus.cpu_addr = 9'(a);
    cpu_bus.cpu_rnw  = 1'b1;
    cpu_bus.pal_cs   = 1'b1;
    @(posedge clk); #1;
    cpu_bus.pal_cs = 1'b0;
    check_val("pal_rd", {24'd0, cpu_bus.pal_dout}, pal_m[a]);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    LHBL = 1'b1;
    LVBL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pxl_cen = 1'(i & 1);
      @(posedge clk); #1;
      exp_rgb = 0; exp_h = 0; exp_v = 0;
      check_out("rst");
      check_val("rst_pal_dout", {24'd0, cpu_bus.pal_dout}, 0);
    end
    pxl_cen = 1'b0;
    rstn    = 1'b1;
    n_pix   = 0;
  endtask

  function automatic int rnd_pix();
    int p, c;
    p = 0;
    for (int k = 0; k < L; k++) begin
      c = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
      p = p | ((($urandom_range(0, 7) << 4) | c) << (k * PXLW));
    end
    return p;
  endfunction

  initial begin
    int old10, a;
    cpu_bus.cpu_cen  = 1'b0;
    cpu_bus.pal_cs   = 1'b0;
    cpu_bus.cpu_rnw  = 1'b1;
    cpu_bus.cpu_addr = '0;
    cpu_bus.cpu_dout = '0;
    do_reset();

    for (int i = 0; i < 512; i++) cpu_write(i, $urandom_range(0, 255), 1);

    // CPU write/readback of entry 1 and a gated (no cpu_cen) write attempt
    cpu_write(2, 8'h1F, 1);
    cpu_write(3, 8'h7C, 1);
    cpu_read(2);
    cpu_read(3);
    cpu_write(2, 8'h55, 0);
    cpu_read(2);
    pstep(8'h01, 3, 0, 1, 1, -1, 0);
    pstep(0, 3, 0, 1, 1, -1, 0);
    pstep(0, 3, 0, 1, 1, -1, 0);
    check_val("entry1_red", {27'd0, red}, 31);
    check_val("entry1_green", {27'd0, green}, 0);
    check_val("entry1_blue", {27'd0, blue}, 31);

    // Priority, transparency, backdrop
    pstep((8'h12 << 7) | 8'h01, 3, 0, 1, 1, -1, 0);
    pstep((8'h12 << 7) | 8'h01, 3, 1, 1, 1, -1, 0);
    pstep((8'h25 << 7) | 8'h10, 3, 0, 1, 1, -1, 0);
    pstep((8'h40 << 7) | 8'h30, 3, 0, 1, 1, -1, 0);
    pstep((8'h40 << 7) | 8'h30, 3, 1, 1, 1, -1, 0);
    pstep((8'h12 << 7) | 8'h01, 2, 0, 1, 1, -1, 0);

    // One-pixel horizontal blank, then one-pixel vertical blank
    pstep(8'h07, 3, 0, 1, 1, -1, 0);
    pstep(8'h07, 3, 0, 0, 1, -1, 0);
    pstep(8'h07, 3, 0, 1, 1, -1, 0);
    pstep(8'h07, 3, 0, 1, 0, -1, 0);
    pstep(8'h07, 3, 0, 1, 1, -1, 0);
    pstep(8'h07, 3, 0, 1, 1, -1, 0);
    check_val("blank_recover_h", {31'd0, LHBL_dly}, 1);

    // Write entry 5 on the same clk the video side reads it
    old10 = pal_m[10];
    pstep(8'h05, 3, 0, 1, 1, -1, 0);
    pstep(8'h05, 3, 0, 1, 1, 10, old10 ^ 8'hFF);
    pstep(8'h05, 3, 0, 1, 1, -1, 0);
    pstep(0, 3, 0, 1, 1, -1, 0);
    pstep(0, 3, 0, 1, 1, -1, 0);

    // Mid-line reset keeps palette contents
    do_reset();
    cpu_read(2);
    cpu_read(3);
    cpu_read(10);
    for (int i = 0; i < 4; i++) pstep(rnd_pix(), 3, i & 1, 1, 1, -1, 0);

    // Random traffic: pixels, idle gaps, CPU writes and reads
    for (int i = 0; i < 300; i++) begin
      pstep(rnd_pix(), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 3,
            $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? 0 : 1, ($urandom_range(0, 7) == 0) ? 0 : 1,
            ($urandom_range(0, 9) == 0) ? $urandom_range(0, 511) : -1, $urandom_range(0, 255));
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        a = $urandom_range(0, 511);
        if ($urandom_range(0, 1) == 0) cpu_write(a, $urandom_range(0, 255), $urandom_range(0, 3) != 0);
        else cpu_read(a);
        check_out("hold");
      end
    end
    pstep(0, 3, 0, 1, 1, -1, 0);
    pstep(0, 3, 0, 1, 1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
